// File: rtl/elelock_pkg.sv
// Shared types and helpers for the electronic-lock keypad controller.
// Holds the state encoding, digit width and the one-hot key encoder.
package elelock_pkg;

  localparam int DIGIT_W = 4;
  localparam int CNT_W   = 4;

  typedef enum logic [2:0] {
    ST_LOCKED   = 3'd0,
    ST_ENTRY    = 3'd1,
    ST_CHECK    = 3'd2,
    ST_UNLOCKED = 3'd3,
    ST_LOCKOUT  = 3'd4
  } state_t;

  typedef struct packed {
    logic               valid;
    logic [DIGIT_W-1:0] bcd;
  } key_t;

  // Valid only when exactly one key is down; bcd is the index of that key.
  function automatic key_t keyenc(input logic [9:0] key);
    key_t       r;
    logic [3:0] ones;
    r.bcd = 4'd0;
    ones  = 4'd0;
    for (int i = 0; i < 10; i++) begin
      r.bcd = key[i] ? 4'(i) : r.bcd;
      ones  = ones + {3'b000, key[i]};
    end
    r.valid = (ones == 4'd1);
    return r;
  endfunction

endpackage

// File: rtl/elelock_if.sv
// Keypad/status bundle between the lock panel and the controller.
interface elelock_if;
  import elelock_pkg::*;

  logic [9:0]       tenkey;
  logic             close;
  logic             lock;
  logic             alarm;
  logic [CNT_W-1:0] digit_cnt;
  logic [CNT_W-1:0] fail_cnt;

  modport master (output tenkey, close, input lock, alarm, digit_cnt, fail_cnt);
  modport slave  (input tenkey, close, output lock, alarm, digit_cnt, fail_cnt);
endinterface

// File: rtl/elelock_keyscan.sv
// Key-press detector: one event per clean press from an idle pad.
module elelock_keyscan
  import elelock_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [9:0]         tenkey,
  output logic               press,
  output logic [DIGIT_W-1:0] digit
);

  logic [9:0] tenkey_q;
  key_t       enc_s;

  // Previous pad sample; a press needs the pad to have been idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tenkey_q <= 10'd0;
    end else begin
      tenkey_q <= tenkey;
    end
  end

  assign enc_s = keyenc(tenkey);
  assign press = enc_s.valid && (tenkey_q == 10'd0);
  assign digit = enc_s.bcd;

endmodule

// File: rtl/elelock_ctrl.sv
// Code-entry state machine for the electronic lock: collects digits, checks the
// secret, counts failures, enforces lockout and relocks on timeout.
module elelock_ctrl
  import elelock_pkg::*;
#(
  parameter int                          DIGITS      = 4,
  parameter logic [DIGIT_W*DIGITS-1:0]   SECRET      = 16'h3712,
  parameter int                          MAX_FAIL    = 3,
  parameter int                          ENTRY_TO    = 200,
  parameter int                          RELOCK_CYC  = 500,
  parameter int                          LOCKOUT_CYC = 1000
) (
  input logic       clk,
  input logic       reset,
  elelock_if.slave  bus
);

  localparam int EW   = DIGIT_W * DIGITS;
  localparam int TMAX = (ENTRY_TO > RELOCK_CYC)
                      ? ((ENTRY_TO > LOCKOUT_CYC) ? ENTRY_TO : LOCKOUT_CYC)
                      : ((RELOCK_CYC > LOCKOUT_CYC) ? RELOCK_CYC : LOCKOUT_CYC);
  localparam int TW   = $clog2(TMAX + 1);

  state_t             state_r, state_s;
  logic [EW-1:0]      entry_r, entry_s;
  logic [CNT_W-1:0]   digit_cnt_r, digit_cnt_s;
  logic [CNT_W-1:0]   fail_cnt_r, fail_cnt_s, fail_inc_s;
  logic [TW-1:0]      timer_r, timer_s;
  logic               lock_r, alarm_r;
  logic               press_s;
  logic [DIGIT_W-1:0] digit_s;

  elelock_keyscan u_keyscan (
    .clk    (clk),
    .reset  (reset),
    .tenkey (bus.tenkey),
    .press  (press_s),
    .digit  (digit_s)
  );

  // State, datapath and registered outputs; lock/alarm follow the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_LOCKED;
      entry_r     <= {EW{1'b1}};
      digit_cnt_r <= 4'd0;
      fail_cnt_r  <= 4'd0;
      timer_r     <= {TW{1'b0}};
      lock_r      <= 1'b1;
      alarm_r     <= 1'b0;
    end else begin
      state_r     <= state_s;
      entry_r     <= entry_s;
      digit_cnt_r <= digit_cnt_s;
      fail_cnt_r  <= fail_cnt_s;
      timer_r     <= timer_s;
      lock_r      <= (state_s != ST_UNLOCKED);
      alarm_r     <= (state_s == ST_LOCKOUT);
    end
  end

  // Next-state and datapath update; the timer holds at zero instead of wrapping.
  always_comb begin
    state_s     = state_r;
    entry_s     = entry_r;
    digit_cnt_s = digit_cnt_r;
    fail_cnt_s  = fail_cnt_r;
    timer_s     = (timer_r == {TW{1'b0}}) ? timer_r : timer_r - TW'(1);
    fail_inc_s  = (fail_cnt_r >= 4'(MAX_FAIL)) ? fail_cnt_r : fail_cnt_r + 4'd1;
    case (state_r)
      ST_LOCKED: begin
        if (press_s) begin
          state_s     = ST_ENTRY;
          entry_s     = {{(EW-DIGIT_W){1'b1}}, digit_s};
          digit_cnt_s = 4'd1;
          timer_s     = TW'(ENTRY_TO - 1);
        end else begin
          state_s = ST_LOCKED;
        end
      end
      ST_ENTRY: begin
        if (bus.close || (!press_s && timer_r == {TW{1'b0}})) begin
          state_s     = ST_LOCKED;
          entry_s     = {EW{1'b1}};
          digit_cnt_s = 4'd0;
        end else if (press_s) begin
          entry_s     = {entry_r[EW-DIGIT_W-1:0], digit_s};
          digit_cnt_s = digit_cnt_r + 4'd1;
          timer_s     = TW'(ENTRY_TO - 1);
          state_s     = (digit_cnt_r + 4'd1 == 4'(DIGITS)) ? ST_CHECK : ST_ENTRY;
        end else begin
          state_s = ST_ENTRY;
        end
      end
      ST_CHECK: begin
        digit_cnt_s = 4'd0;
        entry_s     = {EW{1'b1}};
        if (entry_r == SECRET) begin
          state_s    = ST_UNLOCKED;
          fail_cnt_s = 4'd0;
          timer_s    = TW'(RELOCK_CYC - 1);
        end else if (fail_inc_s == 4'(MAX_FAIL)) begin
          state_s    = ST_LOCKOUT;
          fail_cnt_s = fail_inc_s;
          timer_s    = TW'(LOCKOUT_CYC - 1);
        end else begin
          state_s    = ST_LOCKED;
          fail_cnt_s = fail_inc_s;
        end
      end
      ST_UNLOCKED: begin
        if (bus.close || timer_r == {TW{1'b0}}) begin
          state_s = ST_LOCKED;
        end else begin
          state_s = ST_UNLOCKED;
        end
      end
      ST_LOCKOUT: begin
        if (timer_r == {TW{1'b0}}) begin
          state_s    = ST_LOCKED;
          fail_cnt_s = 4'd0;
        end else begin
          state_s = ST_LOCKOUT;
        end
      end
      default: begin
        state_s     = ST_LOCKED;
        entry_s     = {EW{1'b1}};
        digit_cnt_s = 4'd0;
      end
    endcase
  end

  assign bus.lock      = lock_r;
  assign bus.alarm     = alarm_r;
  assign bus.digit_cnt = digit_cnt_r;
  assign bus.fail_cnt  = fail_cnt_r;

endmodule

// File: tb/tb_elelock_ctrl.sv
// Directed bench for elelock_ctrl with hand-computed expectations.
module tb_elelock_ctrl;
  import elelock_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  elelock_if bus ();

  elelock_ctrl #(
    .DIGITS(4), .SECRET(16'h3712), .MAX_FAIL(3),
    .ENTRY_TO(20), .RELOCK_CYC(30), .LOCKOUT_CYC(50)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Key held 2 cycles, released 2 cycles; capture happens on the first edge.
  task automatic press(input int d);
    bus.tenkey = 10'd1 << d;
    ticks(2);
    bus.tenkey = 10'd0;
    ticks(2);
  endtask

  task automatic enter4(input int a, input int b, input int c, input int d);
    press(a); press(b); press(c); press(d);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b1;
    bus.tenkey = 10'd0;
    bus.close  = 1'b0;
    ticks(2);
    chk("rst_lock",  32'(bus.lock), 32'd1);
    chk("rst_alarm", 32'(bus.alarm), 32'd0);
    chk("rst_dcnt",  32'(bus.digit_cnt), 32'd0);
    chk("rst_fcnt",  32'(bus.fail_cnt), 32'd0);
    reset = 1'b0;
    tick();

    // 1: correct code, lock falls at E+1, relocks 30 cycles later
    press(3); press(7); press(1);
    bus.tenkey = 10'd1 << 2;
    tick();
    chk("t1_dcnt_E", 32'(bus.digit_cnt), 32'd4);
    chk("t1_lock_E", 32'(bus.lock), 32'd1);
    tick();
    chk("t1_lock_U", 32'(bus.lock), 32'd0);
    chk("t1_dcnt_U", 32'(bus.digit_cnt), 32'd0);
    bus.tenkey = 10'd0;
    ticks(2);
    ticks(27);
    chk("t1_lock_U29", 32'(bus.lock), 32'd0);
    tick();
    chk("t1_lock_U30", 32'(bus.lock), 32'd1);
    chk("t1_fcnt", 32'(bus.fail_cnt), 32'd0);

    // 2: close 5 cycles after unlock, then a wrong code
    do_reset();
    enter4(3, 7, 1, 2);
    ticks(3);
    chk("t2_lock_open", 32'(bus.lock), 32'd0);
    bus.close = 1'b1;
    tick();
    bus.close = 1'b0;
    chk("t2_lock_close", 32'(bus.lock), 32'd1);
    enter4(1, 2, 3, 4);
    chk("t2_lock_wrong", 32'(bus.lock), 32'd1);
    chk("t2_fcnt", 32'(bus.fail_cnt), 32'd1);

    // 3: three failures, 50-cycle lockout ignoring the correct code
    do_reset();
    enter4(9, 9, 9, 9);
    chk("t3_fcnt1", 32'(bus.fail_cnt), 32'd1);
    enter4(9, 9, 9, 9);
    chk("t3_fcnt2", 32'(bus.fail_cnt), 32'd2);
    chk("t3_alarm2", 32'(bus.alarm), 32'd0);
    press(9); press(9); press(9);
    bus.tenkey = 10'd1 << 9;
    tick();
    chk("t3_alarm_E", 32'(bus.alarm), 32'd0);
    tick();
    chk("t3_alarm_L", 32'(bus.alarm), 32'd1);
    chk("t3_fcnt3", 32'(bus.fail_cnt), 32'd3);
    bus.tenkey = 10'd0;
    enter4(3, 7, 1, 2);
    chk("t3_lo_lock", 32'(bus.lock), 32'd1);
    chk("t3_lo_dcnt", 32'(bus.digit_cnt), 32'd0);
    ticks(33);
    chk("t3_alarm_L49", 32'(bus.alarm), 32'd1);
    tick();
    chk("t3_alarm_L50", 32'(bus.alarm), 32'd0);
    chk("t3_fcnt_clr", 32'(bus.fail_cnt), 32'd0);
    enter4(3, 7, 1, 2);
    chk("t3_unlock", 32'(bus.lock), 32'd0);

    // 4: partial entry abandoned after 20 idle cycles
    do_reset();
    press(3); press(7);
    chk("t4_dcnt2", 32'(bus.digit_cnt), 32'd2);
    ticks(16);
    chk("t4_dcnt_P19", 32'(bus.digit_cnt), 32'd2);
    tick();
    chk("t4_dcnt_P20", 32'(bus.digit_cnt), 32'd0);
    enter4(3, 7, 1, 2);
    chk("t4_unlock", 32'(bus.lock), 32'd0);

    // 5: held key, multi-hot pad, key-to-key slide
    do_reset();
    bus.tenkey = 10'd1 << 3;
    ticks(10);
    chk("t5_held", 32'(bus.digit_cnt), 32'd1);
    bus.tenkey = 10'd0;
    tick();
    bus.close = 1'b1;
    tick();
    bus.close = 1'b0;
    chk("t5_abort", 32'(bus.digit_cnt), 32'd0);
    bus.tenkey = 10'b0000001010;
    ticks(2);
    chk("t5_multihot", 32'(bus.digit_cnt), 32'd0);
    bus.tenkey = 10'd0;
    tick();
    bus.tenkey = 10'd1 << 3;
    tick();
    bus.tenkey = 10'd1 << 7;
    ticks(2);
    chk("t5_slide", 32'(bus.digit_cnt), 32'd1);
    bus.tenkey = 10'd0;
    tick();

    // 6: asynchronous reset mid-entry and while unlocked
    do_reset();
    press(3); press(7); press(1);
    chk("t6_dcnt3", 32'(bus.digit_cnt), 32'd3);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_async_dcnt", 32'(bus.digit_cnt), 32'd0);
    chk("t6_async_lock", 32'(bus.lock), 32'd1);
    tick();
    reset = 1'b0;
    tick();
    enter4(3, 7, 1, 2);
    chk("t6_unlock", 32'(bus.lock), 32'd0);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_async_relock", 32'(bus.lock), 32'd1);
    tick();
    reset = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/elelock_ctrl.md
# elelock_ctrl

Keypad sequencing controller for the electronic lock. Collects a multi-digit code from the one-hot ten-key pad and compares it against a parameterised secret. It also counts failed attempts, enforces a timed lockout after repeated failures and re-locks automatically after a timeout. It replaces the free-running two-digit shift-and-match path with an explicit state machine and drives the `lock` and `alarm` outputs.

## Interface
Parameters:
- `DIGITS`, 4: code length in digits; legal range 2–8.
- `SECRET`, 16'h3712: secret code, 4·DIGITS bits, BCD. The first digit entered is in the most-significant nibble.
- `MAX_FAIL`, 3: consecutive failed attempts that trigger lockout (≥1).
- `ENTRY_TO`, 200: cycles without a press that abandon a partial entry.
- `RELOCK_CYC`, 500: cycles in UNLOCKED before automatic relock.
- `LOCKOUT_CYC`, 1000: lockout duration in cycles.

Ports:
- `clk`, in, 1: single clock; all logic is on the rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `tenkey`, in, 10: one-hot pad; bit n is digit n. Synchronous to `clk`.
- `close`, in, 1: relock/abort request, sampled each edge.
- `lock`, out, 1: 1 = bolt engaged.
- `alarm`, out, 1: 1 while in LOCKOUT.
- `digit_cnt`, out, 4: number of digits entered so far in the current attempt.
- `fail_cnt`, out, 4: consecutive failed attempts.

## Operation
- **Press event**: `tenkey` is exactly one-hot AND the previous sampled `tenkey` (`tenkey_q`) is 0.
  - Multi-hot or zero values are never events.
  - A held key produces one event only.
  - Changing directly from one key to another produces no event, because `tenkey_q` is nonzero.
- **States**: LOCKED, ENTRY, CHECK, UNLOCKED, LOCKOUT. Reset state is LOCKED.
- **LOCKED**:
  - A press stores the digit in `entry`, sets `digit_cnt` to 1 and moves to ENTRY.
  - `close` has no effect.
- **ENTRY**:
  - A press shifts the digit into `entry` and increments `digit_cnt`. On the press that makes `digit_cnt` equal to DIGITS, move to CHECK.
  - `close`, or ENTRY_TO cycles without a press, moves to LOCKED, clears `digit_cnt` and `entry`, and leaves `fail_cnt` unchanged.
  - `close` and a press on the same edge: `close` wins and the digit is discarded.
- **CHECK**: lasts exactly one cycle and ignores presses.
  - If `entry` equals SECRET: move to UNLOCKED and clear `fail_cnt`.
  - Otherwise increment `fail_cnt`. If the new value equals MAX_FAIL, move to LOCKOUT; else move to LOCKED.
  - `digit_cnt` is cleared on exit in both cases.
- **UNLOCKED**:
  - Presses are ignored.
  - `close`, or expiry of RELOCK_CYC, moves to LOCKED.
- **LOCKOUT**:
  - Presses and `close` are ignored.
  - After LOCKOUT_CYC cycles, move to LOCKED and clear `fail_cnt`.
- **Outputs** (all registered):
  - `lock` = 0 only in UNLOCKED.
  - `alarm` = 1 only in LOCKOUT.
- **Reset values**: `lock` = 1, `alarm` = 0, `digit_cnt` = 0, `fail_cnt` = 0, `entry` = all-ones (0xF nibbles, never a valid digit), `tenkey_q` = 0, timer = 0.
- **Timer**: one shared down-counter, `$clog2(max(ENTRY_TO, RELOCK_CYC, LOCKOUT_CYC)+1)` bits.
  - Loaded on entry to ENTRY and on every press in ENTRY (with ENTRY_TO−1), on entry to UNLOCKED (with RELOCK_CYC−1), and on entry to LOCKOUT (with LOCKOUT_CYC−1).
  - It expires when it equals 0 while in the owning state.
  - It never wraps: it holds at 0.
- `fail_cnt` saturates at MAX_FAIL.

## Timing
- The press is captured at edge E, where `tenkey` becomes one-hot; `digit_cnt` updates at E.
- The final digit is captured at edge E. The FSM is in CHECK for cycle E→E+1. `lock` and `alarm` update at E+1.
- UNLOCKED is entered at edge U, so `lock` falls at U. With no `close`, `lock` rises at edge U+RELOCK_CYC.
- LOCKOUT is entered at edge L, so `alarm` rises at L and falls at L+LOCKOUT_CYC.
- ENTRY timeout: with the last press at edge P, return to LOCKED occurs at edge P+ENTRY_TO.
- `close` asserted at edge C in UNLOCKED or ENTRY: LOCKED is entered at C, with `lock` = 1 from C.
- Reset asserted mid-operation forces reset values immediately, without waiting for a clock edge. Release is synchronous to the next edge.

## Structure
- Package `elelock_pkg`:
  - State encoding constants.
  - `keyenc` function: one-hot→BCD plus a valid flag, where valid = exactly one bit set.
  - Digit width constant, 4.
- One sub-module, `elelock_keyscan`:
  - Holds the `tenkey_q` register and the edge/one-hot detection.
  - Outputs `press` (1 bit) and `digit` (4 bits).
- The FSM, timer, `entry` shift register and counters live in `elelock_ctrl`.

## Test plan
Parameters for all scenarios: DIGITS=4, SECRET=16'h3712, MAX_FAIL=3, ENTRY_TO=20, RELOCK_CYC=30, LOCKOUT_CYC=50.

1. Reset, then press 3,7,1,2 (each held 2 cycles, released 2 cycles) → `lock` falls one cycle after the "2" capture edge and rises 30 cycles later; `fail_cnt` = 0.
2. Enter 3,7,1,2, then assert `close` 5 cycles after unlock → `lock` = 1 at that edge; a subsequent 1,2,3,4 leaves `lock` = 1 and gives `fail_cnt` = 1.
3. Enter three wrong codes (9,9,9,9) → `fail_cnt` goes 1,2,3; `alarm` = 1 for exactly 50 cycles; the correct code entered during lockout is ignored; afterwards `fail_cnt` = 0 and the correct code unlocks.
4. Press 3,7, then idle 20 cycles → `digit_cnt` returns to 0 at the 20th edge; then 3,7,1,2 unlocks.
5. Hold key 3 for 10 cycles, or drive 10'b0000001010, or switch from key 3 to key 7 without releasing → `digit_cnt` = 1, 0 and 1 respectively.
6. Assert `reset` asynchronously with 3,7,1 entered → `digit_cnt` = 0, `lock` = 1 before the next edge; a following 3,7,1,2 unlocks.
